// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM state, in-flight read tag and prefetch entry.
package ifu_pkg;

  localparam int IFU_ADDR_W = 8;
  localparam int IFU_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ifu_state_t;

  typedef struct packed {
    logic                  valid;
    logic [IFU_ADDR_W-1:0] pc;
    logic                  epoch;
  } inflight_t;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with clear; head visible combinationally from storage, zero when empty.
// Push while full is accepted only together with a pop; clear overrides push and pop.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential fetch from a 1-cycle-latency memory into a prefetch queue; first instruction 3 cycles after start.
// Requests stop while queued + in-flight words fill the queue; IFU_PERF_EN adds perf_fetched/perf_stall counters.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W     = IFU_ADDR_W,
  parameter int                DATA_W     = IFU_DATA_W,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              busy
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_t        state;
  ifu_state_t        state_d;
  inflight_t         infl;
  logic [ADDR_W-1:0] pc;
  logic              epoch;
  logic              issue;
  logic              flush;
  logic              push;
  logic              pop;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              fifo_full;
  logic              fifo_empty;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;

  // The in-flight word already owns a queue slot, so it counts toward occupancy.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, infl.valid};
  assign issue     = (state == RUN) && !stop && !redirect_valid && !fifo_full &&
                     (occupancy < (CW+1)'(FIFO_DEPTH));
  assign flush     = (state == RUN) && (stop || redirect_valid);
  assign push      = infl.valid && (infl.epoch == epoch);
  assign pop       = instr_valid && instr_ready;
  assign push_entry = '{pc: infl.pc, data: mem_readdata};

  assign mem_address    = pc;
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_clken      = ~reset;
  assign busy           = (state == RUN);
  assign instr_valid    = !fifo_empty;
  assign instr_data     = head.data;
  assign instr_pc       = head.pc;

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      epoch <= 1'b0;
      infl  <= '0;
    end else begin
      state <= state_d;
      infl  <= '{valid: issue, pc: pc, epoch: epoch};
      if (state == IDLE) begin
        if (start) pc <= RESET_PC;
      end else if (!stop) begin
        if (redirect_valid) begin
          pc    <= redirect_pc;
          epoch <= ~epoch;
        end else if (issue) begin
          pc <= pc + 1'b1;
        end
      end
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else if ((state == IDLE) && start) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 1'b1;
      if ((state == RUN) && instr_ready && !instr_valid && (perf_stall != '1))
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table for startup/backpressure, directed redirect/stop/reset, randomized scoreboard.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        instr_ready = 1'b0;

  logic [7:0]  mem_address0, instr_pc0, mem_address1, instr_pc1;
  logic        mem_cs0, mem_write0, mem_clken0, instr_valid0, busy0;
  logic        mem_cs1, mem_write1, mem_clken1, instr_valid1, busy1;
  logic [31:0] mem_rd0, instr_data0, mem_rd1, instr_data1;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched0, perf_stall0, perf_fetched1, perf_stall1;
`endif

  // Memory model: word k holds 0xA000_0000 + k, address registered on chipselect.
  logic [7:0]  maddr0_q = 8'h00;
  logic [7:0]  maddr1_q = 8'h00;
  always @(posedge clk) begin
    if (mem_cs0) maddr0_q <= mem_address0;
    if (mem_cs1) maddr1_q <= mem_address1;
  end
  assign mem_rd0 = 32'hA000_0000 + {24'h0, maddr0_q};
  assign mem_rd1 = 32'hA000_0000 + {24'h0, maddr1_q};

  instr_fetch_unit #(.RESET_PC(8'h00)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_address(mem_address0), .mem_chipselect(mem_cs0), .mem_write(mem_write0),
    .mem_clken(mem_clken0), .mem_readdata(mem_rd0),
    .instr_valid(instr_valid0), .instr_data(instr_data0), .instr_pc(instr_pc0),
    .instr_ready(instr_ready), .busy(busy0)
`ifdef IFU_PERF_EN
    , .perf_fetched(perf_fetched0), .perf_stall(perf_stall0)
`endif
  );

  instr_fetch_unit #(.RESET_PC(8'hFE)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_address(mem_address1), .mem_chipselect(mem_cs1), .mem_write(mem_write1),
    .mem_clken(mem_clken1), .mem_readdata(mem_rd1),
    .instr_valid(instr_valid1), .instr_data(instr_data1), .instr_pc(instr_pc1),
    .instr_ready(instr_ready), .busy(busy1)
`ifdef IFU_PERF_EN
    , .perf_fetched(perf_fetched1), .perf_stall(perf_stall1)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       start;
    logic       ready;
    logic       cs;
    logic [7:0] addr;
    logic       vld;
    logic [7:0] pc;
    logic       busy;
  } vec_t;

  vec_t tbl [16];

  logic [7:0] exp_pc;
  int         reqs, pops, total_pops;

  initial begin
    // Startup with 10 cycles of backpressure, then release (row index = cycles after start).
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 8'd0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 8'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 8'd0, 1'b1};
    for (int i = 5; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 8'd1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'd5, 1'b1, 8'd2, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 8'd3, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 8'd7, 1'b1, 8'd4, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 8'd8, 1'b1, 8'd5, 1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr", {24'h0, mem_address0}, 32'h0);
    chk("rst_cs", {31'h0, mem_cs0}, 32'h0);
    chk("rst_write", {31'h0, mem_write0}, 32'h0);
    chk("rst_clken", {31'h0, mem_clken0}, 32'h0);
    chk("rst_vld", {31'h0, instr_valid0}, 32'h0);
    chk("rst_data", instr_data0, 32'h0);
    chk("rst_pc", {24'h0, instr_pc0}, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("clken_after_rst", {31'h0, mem_clken0}, 32'h1);
    @(negedge clk);

    // Table: startup latency, fill to 4 requests, release without gap; dut1 shows the 0xFE wrap.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start       = tbl[i].start;
      instr_ready = tbl[i].ready;
      #1;
      chk($sformatf("tbl%0d_cs", i), {31'h0, mem_cs0}, {31'h0, tbl[i].cs});
      chk($sformatf("tbl%0d_vld", i), {31'h0, instr_valid0}, {31'h0, tbl[i].vld});
      chk($sformatf("tbl%0d_busy", i), {31'h0, busy0}, {31'h0, tbl[i].busy});
      chk($sformatf("tbl%0d_wrap_vld", i), {31'h0, instr_valid1}, {31'h0, tbl[i].vld});
      if (tbl[i].cs) begin
        chk($sformatf("tbl%0d_addr", i), {24'h0, mem_address0}, {24'h0, tbl[i].addr});
        chk($sformatf("tbl%0d_wrap_addr", i), {24'h0, mem_address1}, {24'h0, 8'(tbl[i].addr + 8'hFE)});
      end
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i), {24'h0, instr_pc0}, {24'h0, tbl[i].pc});
        chk($sformatf("tbl%0d_data", i), instr_data0, 32'hA000_0000 + {24'h0, tbl[i].pc});
        chk($sformatf("tbl%0d_wrap_pc", i), {24'h0, instr_pc1}, {24'h0, 8'(tbl[i].pc + 8'hFE)});
        chk($sformatf("tbl%0d_wrap_data", i), instr_data1,
            32'hA000_0000 + {24'h0, 8'(tbl[i].pc + 8'hFE)});
      end
    end
    start = 1'b0;

    // Stop, then restart and redirect to 0x40 with three words buffered.
    @(negedge clk);
    stop = 1'b1; instr_ready = 1'b0;
    #1 chk("stop_cs", {31'h0, mem_cs0}, 32'h0);
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("stop_busy", {31'h0, busy0}, 32'h0);
    chk("stop_vld", {31'h0, instr_valid0}, 32'h0);
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    #1;
    chk("redir_R_cs", {31'h0, mem_cs0}, 32'h0);
    chk("redir_R_vld", {31'h0, instr_valid0}, 32'h1);
    chk("redir_R_pc", {24'h0, instr_pc0}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    #1;
    chk("redir_R1_vld", {31'h0, instr_valid0}, 32'h0);
    chk("redir_R1_cs", {31'h0, mem_cs0}, 32'h1);
    chk("redir_R1_addr", {24'h0, mem_address0}, 32'h40);
    @(negedge clk);
    #1;
    chk("redir_R2_vld", {31'h0, instr_valid0}, 32'h0);
    chk("redir_R2_addr", {24'h0, mem_address0}, 32'h41);
    @(negedge clk);
    #1;
    chk("redir_R3_vld", {31'h0, instr_valid0}, 32'h1);
    chk("redir_R3_pc", {24'h0, instr_pc0}, 32'h40);
    chk("redir_R3_data", instr_data0, 32'hA000_0040);
    @(negedge clk);
    #1 chk("redir_R4_pc", {24'h0, instr_pc0}, 32'h41);

    // Stop and redirect in the same cycle: stop wins.
    @(negedge clk);
    stop = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h80;
    #1 chk("stopredir_cs", {31'h0, mem_cs0}, 32'h0);
    @(negedge clk);
    stop = 1'b0; redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stopredir_busy", {31'h0, busy0}, 32'h0);
      chk("stopredir_vld", {31'h0, instr_valid0}, 32'h0);
      chk("stopredir_cs_idle", {31'h0, mem_cs0}, 32'h0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_addr", {24'h0, mem_address0}, 32'h0);
    chk("arst_cs", {31'h0, mem_cs0}, 32'h0);
    chk("arst_write", {31'h0, mem_write0}, 32'h0);
    chk("arst_clken", {31'h0, mem_clken0}, 32'h0);
    chk("arst_vld", {31'h0, instr_valid0}, 32'h0);
    chk("arst_data", instr_data0, 32'h0);
    chk("arst_pc", {24'h0, instr_pc0}, 32'h0);
    chk("arst_busy", {31'h0, busy0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_rel_clken", {31'h0, mem_clken0}, 32'h1);
    chk("arst_rel_vld", {31'h0, instr_valid0}, 32'h0);

    // Randomized run: consumer must see a contiguous pc stream that restarts at each redirect target.
    @(negedge clk);
    start = 1'b1; instr_ready = 1'b0;
    exp_pc = 8'h00; reqs = 0; pops = 0; total_pops = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      start          = 1'b0;
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = 1'b0;
      if (busy0 && ($urandom_range(0, 29) == 0)) begin
        redirect_valid = 1'b1;
        redirect_pc    = 8'($urandom);
      end
      #1;
      if (mem_cs0) chk("rand_outstanding_le_depth", {31'h0, (reqs - pops) < 4}, 32'h1);
      if (instr_valid0 && instr_ready) begin
        chk("rand_pc", {24'h0, instr_pc0}, {24'h0, exp_pc});
        chk("rand_data", instr_data0, 32'hA000_0000 + {24'h0, exp_pc});
        exp_pc = exp_pc + 8'd1;
        pops++;
        total_pops++;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        reqs   = 0;
        pops   = 0;
      end else if (mem_cs0) begin
        reqs++;
      end
    end
    chk("rand_progress", {31'h0, total_pops > 500}, 32'h1);
    @(negedge clk);
    redirect_valid = 1'b0; instr_ready = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

`ifdef IFU_PERF_EN
    // 20 pops; stalls: one after start plus two per redirect.
    begin
      int  pcnt;
      bit  r1, r2;
      pcnt = 0; r1 = 1'b0; r2 = 1'b0;
      @(negedge clk);
      start = 1'b1; instr_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200 && pcnt < 20; c++) begin
        @(negedge clk);
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        if (pcnt == 6 && !r1) begin
          redirect_valid = 1'b1; redirect_pc = 8'h10; r1 = 1'b1;
        end else if (pcnt == 12 && !r2) begin
          redirect_valid = 1'b1; redirect_pc = 8'h20; r2 = 1'b1;
        end
        #1;
        if (instr_valid0 && instr_ready) pcnt++;
      end
      @(negedge clk);
      instr_ready = 1'b0; redirect_valid = 1'b0;
      #1;
      chk("perf_pops_reached", pcnt, 32'd20);
      chk("perf_fetched", perf_fetched0, 32'd20);
      chk("perf_stall", perf_stall0, 32'd5);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction fetch stage sitting directly upstream of the 256 x 32 single-port instruction memory (Avalon slave, 1-cycle read latency: address registered in RAM, data unregistered). Generates word addresses, issues reads, captures returned words with their PC into a small prefetch FIFO, and hands them to the decoder over a valid/ready handshake. Supports start/stop control and branch redirect with flush of stale data.

## Interface
Parameters:
- ADDR_W, 8, word-address width (matches memory depth 256)
- DATA_W, 32, instruction width
- FIFO_DEPTH, 4, prefetch entries (power of two, 2..16)
- RESET_PC, 0, PC loaded on start

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  pulse; begin fetching at RESET_PC (ignored unless IDLE)
- stop  in  1  pulse; abort fetching, flush, return to IDLE
- redirect_valid  in  1  branch redirect strobe (honoured only in RUN)
- redirect_pc  in  ADDR_W  redirect target word address
- mem_address  out  ADDR_W  to memory address
- mem_chipselect  out  1  read request strobe
- mem_write  out  1  constant 0
- mem_clken  out  1  constant 1 outside reset
- mem_readdata  in  DATA_W  memory data, valid 1 cycle after request
- instr_valid  out  1  instruction available
- instr_data  out  DATA_W  instruction word
- instr_pc  out  ADDR_W  word address of instr_data
- instr_ready  in  1  downstream accepts
- busy  out  1  high in RUN

## Operation
- States: IDLE, RUN. IDLE -start-> RUN (pc<=RESET_PC). RUN -stop-> IDLE (FIFO cleared, in-flight response discarded).
- Issue rule (RUN): request when fifo_count + inflight < FIFO_DEPTH and no redirect this cycle; mem_address=pc, mem_chipselect=1, pc<=pc+1.
- pc arithmetic modulo 2^ADDR_W: 255 wraps to 0.
- Response capture: inflight register holds {valid, pc, epoch}; on next cycle mem_readdata pushed with stored pc if epoch matches current epoch.
- Redirect: epoch toggles, FIFO cleared, pc<=redirect_pc; in-flight response dropped; first new request next cycle.
- Pop: instr_valid && instr_ready removes head. Push and pop same cycle allowed at full.
- Simultaneous: stop beats redirect; pop in same cycle as redirect/stop completes (consumer owns that word), remainder flushed; start while RUN ignored.
- Reset mid-operation: immediate return to IDLE, FIFO empty, any in-flight response ignored.

## Timing
- Reset values: mem_address=0, mem_chipselect=0, mem_write=0, mem_clken=0 during reset then 1, instr_valid=0, instr_data=0, instr_pc=0, busy=0.
- start at cycle T -> first request at T+1, data in FIFO at T+3 edge, instr_valid high cycle T+3.
- Steady state with instr_ready=1: one instruction per cycle.
- instr_data/instr_pc driven from FIFO head register; no combinational path from instr_ready to mem_chipselect beyond count compare.
- Redirect at cycle R -> request for redirect_pc at R+1, instr_valid low from R+1 until R+3.

## Configuration
- IFU_PERF_EN: adds output perf_fetched (32 bit, counts popped instructions, saturating, cleared by reset and start) and perf_stall (32 bit, cycles with instr_ready=1 and instr_valid=0 in RUN). Without macro: ports and counters absent; behaviour otherwise identical.

## Structure
- Package ifu_pkg: state enum (IDLE, RUN), inflight struct {valid, pc, epoch}, FIFO entry struct {pc, data}.
- Sub-module ifu_fifo: synchronous FIFO, parameterized depth/width, push/pop/clear, count, full/empty.

## Test plan
- start, instr_ready=1, memory preloaded word k = 0xA000_0000+k -> instr_pc 0,1,2,... with matching data, one per cycle from T+3.
- instr_ready=0 for 10 cycles -> exactly 4 requests issued, FIFO full, no further mem_chipselect; release -> order 0..3 then 4 resumes without gap or duplicate.
- Redirect to 0x40 while 3 entries buffered -> stale entries never visible; next valid instruction pc 0x40 at R+3.
- Start with RESET_PC=0xFE -> pcs 0xFE, 0xFF, 0x00, 0x01 (wrap).
- stop and redirect same cycle -> IDLE, busy=0, FIFO empty, no further requests; reset asserted mid-RUN -> all outputs at reset values asynchronously.
- IFU_PERF_EN: 20 pops with 5 stall cycles -> perf_fetched=20, perf_stall=5.
